ibex_ex_sequencer: RTL
======================

# ibex_ex_sequencer

ID-side counterpart to the execution block:
- Issues each instruction to the EX block by driving the dynamic multiply/divide enables and the ALU first-cycle flag.
- Owns the two 34-bit intermediate-value registers that the EX block reads and writes.
- Consumes the EX valid handshake and registers each finished result into a single-entry retirement slot that feeds writeback.
- Sits between the ID/EX pipeline control and the writeback stage, and takes the lockstep setback used across the core.

## Interface
- MaxCycles, 40: cycle bound for the busy watchdog (used only with IBEX_EX_SEQ_WATCHDOG_EN).
- clk_i  input  1  core clock
- rst_ni  input  1  asynchronous active-low reset
- setback_i  input  1  synchronous lockstep flush
- instr_valid_i  input  1  ID presents an instruction to EX
- mult_sel_i  input  1  static decode: multiply
- div_sel_i  input  1  static decode: divide
- ex_valid_i  input  1  EX result valid this cycle
- result_ex_i  input  32  EX result
- imd_val_we_i  input  2  intermediate register write enables from EX
- imd_val_d_i  input  34x2  intermediate register write data from EX
- wb_ready_i  input  1  writeback accepts the retirement slot
- mult_en_o  output  1  dynamic multiply enable to EX
- div_en_o  output  1  dynamic divide enable to EX
- alu_instr_first_cycle_o  output  1  first EX cycle of the current instruction
- multdiv_ready_id_o  output  1  retirement slot can accept a result this cycle
- imd_val_q_o  output  34x2  intermediate register contents to EX
- ex_done_o  output  1  instruction leaves EX this cycle; ID may advance
- result_o  output  32  registered result to writeback
- result_valid_o  output  1  retirement slot holds a result
- busy_o  output  1  FSM in BUSY
- watchdog_o  output  1  sticky watchdog flag; 0 when the macro is off

## Operation
- FSM states: IDLE and BUSY.
  - IDLE: instr_valid_i & ~accept -> BUSY.
  - BUSY: accept -> IDLE.
  - Either state: instr_valid_i & accept -> IDLE (single-cycle completion).
- accept = ex_valid_i & multdiv_ready_id_o.
- multdiv_ready_id_o = ~result_valid_o | wb_ready_i.
- Enables:
  - mult_en_o = instr_valid_i & mult_sel_i & ~setback_i.
  - div_en_o = instr_valid_i & div_sel_i & ~setback_i.
  - Both enables are held high through BUSY until accept.
- alu_instr_first_cycle_o = instr_valid_i & (state==IDLE).
- ex_done_o = instr_valid_i & accept & ~setback_i.
- Retirement slot:
  - On ex_done_o, capture result_o <= result_ex_i and set result_valid_o.
  - A captured result replaces a slot drained by wb_ready_i in the same cycle.
  - wb_ready_i with no capture clears result_valid_o.
  - result_o holds its value while result_valid_o & ~wb_ready_i.
- Intermediate registers: imd_val_q_o[k] <= imd_val_d_i[k] when imd_val_we_i[k] & ~setback_i. Both lanes are independent and may be written in the same cycle. The registers keep their value across instructions.
- Setback (synchronous, highest priority):
  - state -> IDLE; result_valid_o -> 0; watchdog_o -> 0.
  - Intermediate-register writes are suppressed; register contents are otherwise kept.
  - Enables and ex_done_o are forced low in that cycle.
- instr_valid_i dropping while in BUSY (ID flush) returns the FSM to IDLE with no capture.

## Timing
- Reset values: state IDLE; result_o 0; result_valid_o 0; imd_val_q_o both 0; watchdog_o 0; busy_o 0.
- Single-cycle ALU op: ex_done_o in cycle 0, result_valid_o in cycle 1.
- N-cycle op: ex_done_o in cycle N-1, result_valid_o in cycle N.
- Back-to-back single-cycle ops with wb_ready_i high retire one per cycle.
- Backpressure: when result_valid_o & ~wb_ready_i, ex_valid_i is not accepted. EX holds its final state because multdiv_ready_id_o is low. No result is lost or duplicated.

## Configuration
- IBEX_EX_SEQ_WATCHDOG_EN defined:
  - A cycle counter sized $clog2(MaxCycles+1) increments in BUSY and clears on leaving BUSY.
  - When the counter reaches MaxCycles, watchdog_o sets.
  - watchdog_o is sticky; only reset or setback_i clears it.
  - Sequencing is unaffected.
- Undefined: no counter is built; watchdog_o is tied to 0.

## Test plan
- ALU add, wb_ready_i=1: instr_valid_i and ex_valid_i in cycle 0 with result_ex_i=0x0000_0005 -> ex_done_o=1 in cycle 0; result_valid_o=1 and result_o=0x0000_0005 in cycle 1; busy_o stays 0.
- Divide with ex_valid_i in cycle 36 -> div_en_o high cycles 0-36, busy_o high cycles 1-36, alu_instr_first_cycle_o only in cycle 0, result_valid_o in cycle 37.
- Backpressure: slot full holding 0xA, wb_ready_i=0, ex_valid_i=1 with 0xB -> multdiv_ready_id_o=0 and no capture. Raise wb_ready_i -> 0xB is captured the same cycle, then result_o=0xB.
- Intermediate registers: imd_val_we_i=2'b11 with d[0]=34'h3_0000_0001 and d[1]=34'h1 -> next cycle q[0]=34'h3_0000_0001 and q[1]=34'h1. Repeat the write with setback_i=1 -> values unchanged.
- Setback in BUSY cycle 5 of a multiply -> mult_en_o=0 that cycle, state IDLE next cycle, result_valid_o=0, no ex_done_o.
- Watchdog with the macro defined and MaxCycles=8: hold ex_valid_i=0 for 10 cycles -> watchdog_o=1 from cycle 9 and stays 1. Without the macro, watchdog_o stays 0.

Source files
------------

// File: rtl/ibex_ex_sequencer.sv
// ibex_ex_sequencer
// ID-side sequencer for the execution block. It issues each instruction to EX
// (multiply/divide enables and the ALU first-cycle flag), owns the two 34-bit
// intermediate-value registers EX iterates on, and captures each finished
// result into a single-entry retirement slot that feeds writeback.
//
// Optional feature: define IBEX_EX_SEQ_WATCHDOG_EN to build a busy watchdog
// that sets a sticky flag once the FSM has stayed in BUSY for MaxCycles
// cycles. Without the macro no counter is built and watchdog_o is 0.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   setback_i                synchronous lockstep flush (highest priority)
//   instr_valid_i            ID presents an instruction to EX
//   mult_sel_i, div_sel_i    static multiply/divide decode
//   ex_valid_i, result_ex_i  EX result handshake and data
//   imd_val_we_i/_d_i        intermediate register writes from EX
//   wb_ready_i               writeback drains the retirement slot
//   mult_en_o, div_en_o      dynamic multiply/divide enables to EX
//   alu_instr_first_cycle_o  first EX cycle of the current instruction
//   multdiv_ready_id_o       slot can take a result this cycle
//   imd_val_q_o              intermediate register contents to EX
//   ex_done_o                instruction leaves EX this cycle
//   result_o, result_valid_o retirement slot contents
//   busy_o                   FSM is in BUSY
//   watchdog_o               sticky busy-timeout flag
module ibex_ex_sequencer #(
    parameter int unsigned MaxCycles = 40
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             setback_i,
    input  logic             instr_valid_i,
    input  logic             mult_sel_i,
    input  logic             div_sel_i,
    input  logic             ex_valid_i,
    input  logic [31:0]      result_ex_i,
    input  logic [1:0]       imd_val_we_i,
    input  logic [1:0][33:0] imd_val_d_i,
    input  logic             wb_ready_i,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             alu_instr_first_cycle_o,
    output logic             multdiv_ready_id_o,
    output logic [1:0][33:0] imd_val_q_o,
    output logic             ex_done_o,
    output logic [31:0]      result_o,
    output logic             result_valid_o,
    output logic             busy_o,
    output logic             watchdog_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             result_valid_q, result_valid_d;
    logic [31:0]      result_q, result_d;
    logic [1:0][33:0] imd_val_q, imd_val_d;
    logic             accept;

    // The slot can take a new result if it is empty or being drained now.
    assign multdiv_ready_id_o = ~result_valid_q | wb_ready_i;
    assign accept             = ex_valid_i & multdiv_ready_id_o;

    // Enables follow instr_valid_i, which ID holds high for the whole
    // instruction, so they stay up through BUSY until the result is accepted.
    assign mult_en_o               = instr_valid_i & mult_sel_i & ~setback_i;
    assign div_en_o                = instr_valid_i & div_sel_i & ~setback_i;
    assign alu_instr_first_cycle_o = instr_valid_i & (state_q == IDLE);
    assign ex_done_o               = instr_valid_i & accept & ~setback_i;

    assign busy_o         = (state_q == BUSY);
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign imd_val_q_o    = imd_val_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (instr_valid_i && !accept) state_d = BUSY;
            // Dropping instr_valid_i in BUSY is an ID flush: back to IDLE.
            BUSY: if (accept || !instr_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (instr_valid_i && accept) state_d = IDLE;
        if (setback_i)               state_d = IDLE;
    end

    // Retirement slot and intermediate registers
    always_comb begin
        result_d       = result_q;
        result_valid_d = result_valid_q;
        imd_val_d      = imd_val_q;
        if (ex_done_o) begin
            // A capture wins over a same-cycle drain: the slot refills.
            result_d       = result_ex_i;
            result_valid_d = 1'b1;
        end else if (wb_ready_i) begin
            result_valid_d = 1'b0;
        end
        if (setback_i) result_valid_d = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (imd_val_we_i[k] && !setback_i) imd_val_d[k] = imd_val_d_i[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            imd_val_q      <= '0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            imd_val_q      <= imd_val_d;
        end
    end

`ifdef IBEX_EX_SEQ_WATCHDOG_EN
    localparam int unsigned CntW = $clog2(MaxCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            watchdog_q, watchdog_d;

    // Counts cycles spent in BUSY; saturates at MaxCycles so the flag
    // condition stays stable for arbitrarily long stalls.
    always_comb begin
        cnt_d      = cnt_q;
        watchdog_d = watchdog_q;
        if (state_d != BUSY) begin
            cnt_d = '0;
        end else if (state_q == BUSY && cnt_q != CntW'(MaxCycles)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CntW'(MaxCycles) && state_d == BUSY) watchdog_d = 1'b1;
        if (setback_i) begin
            cnt_d      = '0;
            watchdog_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            watchdog_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            watchdog_q <= watchdog_d;
        end
    end

    assign watchdog_o = watchdog_q;
`else
    assign watchdog_o = 1'b0;
`endif

endmodule
